// File: rtl/balu_ise_pipe.sv
// Handshaked bit-manipulation unit: Zbkb ops, rev8/brev8 in one registered cycle,
// clmul/clmulh on an iterative carry-less multiply engine.
module balu_ise_pipe #(
  parameter int XLEN       = 64,
  parameter int CLMUL_STEP = 4,
  parameter int EN_CLMUL   = 1
) (
  input  logic            ise_clk,
  input  logic            ise_rst,
  input  logic [5:0]      ise_fn,
  input  logic [XLEN-1:0] ise_in1,
  input  logic [XLEN-1:0] ise_in2,
  input  logic            ise_val,
  output logic            ise_rdy,
  input  logic            ise_ordy,
  output logic            ise_oval,
  output logic [XLEN-1:0] ise_out
);

  localparam int N  = XLEN / CLMUL_STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic                oval_q, oval_d;
  logic [XLEN-1:0]     out_q, out_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic                hi_q, hi_d;

  logic [XLEN-1:0]     single_res;
  logic [XLEN-1:0]     ror_res, rol_res, rev8_res, brev8_res;
  logic [31:0]         w_in, rorw_res, rolw_res;
  logic [6:0]          sh;
  logic [4:0]          shw;
  logic [2*XLEN-1:0]   step_acc;
  logic                is_clmul, accept;

  assign ise_rdy  = (state_q == IDLE) && (!oval_q || ise_ordy);
  assign accept   = ise_val && ise_rdy;
  assign is_clmul = (EN_CLMUL != 0) && ((ise_fn == 6'd44) || (ise_fn == 6'd45));
  assign ise_oval = oval_q;
  assign ise_out  = out_q;

  // Single-cycle datapath; W-forms only exist when XLEN is 64.
  always_comb begin
    sh        = (XLEN == 64) ? {1'b0, ise_in2[5:0]} : {2'b0, ise_in2[4:0]};
    shw       = ise_in2[4:0];
    w_in      = ise_in1[31:0];
    ror_res   = (ise_in1 >> sh) | (ise_in1 << (7'(XLEN) - sh));
    rol_res   = (ise_in1 << sh) | (ise_in1 >> (7'(XLEN) - sh));
    rorw_res  = (w_in >> shw) | (w_in << (6'd32 - {1'b0, shw}));
    rolw_res  = (w_in << shw) | (w_in >> (6'd32 - {1'b0, shw}));
    rev8_res  = '0;
    brev8_res = '0;
    for (int i = 0; i < XLEN / 8; i++) begin
      rev8_res[8*i +: 8] = ise_in1[XLEN-8-8*i +: 8];
      for (int j = 0; j < 8; j++) brev8_res[8*i+j] = ise_in1[8*i+7-j];
    end
    single_res = '0;
    case (ise_fn)
      6'd32, 6'd34: single_res = ror_res;
      6'd33:        single_res = rol_res;
      6'd35:        single_res = ise_in1 & ~ise_in2;
      6'd36:        single_res = ise_in1 | ~ise_in2;
      6'd37:        single_res = ~(ise_in1 ^ ise_in2);
      6'd38:        single_res = {ise_in2[XLEN/2-1:0], ise_in1[XLEN/2-1:0]};
      6'd39:        single_res = XLEN'({ise_in2[7:0], ise_in1[7:0]});
      6'd40, 6'd42: if (XLEN == 64) single_res = XLEN'(rorw_res);
      6'd41:        if (XLEN == 64) single_res = XLEN'(rolw_res);
      6'd43:        if (XLEN == 64) single_res = XLEN'({ise_in2[15:0], ise_in1[15:0]});
      6'd46:        single_res = rev8_res;
      6'd47:        single_res = brev8_res;
      default:      single_res = '0;
    endcase
  end

  // One clmul iteration: fold STEP partial products into the accumulator.
  always_comb begin
    step_acc = acc_q;
    for (int i = 0; i < CLMUL_STEP; i++) begin
      if (b_q[i]) step_acc = step_acc ^ (a_q << i);
    end
  end

  always_comb begin
    state_d = state_q;
    oval_d  = oval_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE: begin
        if (oval_q && ise_ordy) oval_d = 1'b0;
        if (accept) begin
          if (is_clmul) begin
            a_d     = (2*XLEN)'(ise_in1);
            b_d     = ise_in2;
            hi_d    = (ise_fn == 6'd45);
            acc_d   = '0;
            cnt_d   = '0;
            oval_d  = 1'b0;
            state_d = BUSY;
          end else begin
            out_d  = single_res;
            oval_d = 1'b1;
          end
        end
      end
      BUSY: begin
        acc_d = step_acc;
        a_d   = a_q << CLMUL_STEP;
        b_d   = b_q >> CLMUL_STEP;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          out_d   = hi_q ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
          oval_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ise_clk) begin
    if (!ise_rst) begin
      state_q <= IDLE;
      oval_q  <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      oval_q  <= oval_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
    end
  end

endmodule
